// File: rtl/display_scanner_if.sv
// Load-side bus of the display scanner.
//   value    : 32-bit display value, nibble i shown on digit i
//   load     : single-cycle strobe capturing value/digit_en/dp_in
//   digit_en : per-digit enable, 0 keeps that anode dark
//   dp_in    : per-digit decimal-point request, active-high
// master drives the bus, slave (the scanner) samples it.
interface display_scanner_if;
  logic [31:0] value;
  logic        load;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;

  modport master (output value, output load, output digit_en, output dp_in);
  modport slave  (input value, input load, input digit_en, input dp_in);
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexing scanner for an 8-digit seven-segment display.
// Walks the digits one DIV-cycle slot at a time, presenting the slot nibble to the
// external decoder and driving the active-low anode and decimal point. Loads are
// double-buffered and only become visible at the frame boundary (slot 7 -> 0).
//   clock      : system clock
//   reset      : synchronous active-high reset
//   bus        : load interface (value, load, digit_en, dp_in)
//   digit      : nibble of the current slot, feeds the segment decoder
//   AN         : anodes, active-low
//   DP         : decimal-point cathode, active-low
//   slot       : current slot index
//   frame_done : one-cycle pulse after the slot 7 -> 0 wrap
module display_scanner #(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned BLANK = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  display_scanner_if.slave        bus,
  output logic [3:0]              digit,
  output logic [7:0]              AN,
  output logic                    DP,
  output logic [2:0]              slot,
  output logic                    frame_done
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] LastC  = CntW'(DIV - 1);
  localparam logic [CntW-1:0] BlankC = CntW'(BLANK);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      slot_q, slot_d;
  logic [31:0]     pend_value_q, pend_value_d;
  logic [7:0]      pend_en_q, pend_en_d;
  logic [7:0]      pend_dp_q, pend_dp_d;
  logic            pend_valid_q, pend_valid_d;
  logic [31:0]     act_value_q, act_value_d;
  logic [7:0]      act_en_q, act_en_d;
  logic [7:0]      act_dp_q, act_dp_d;
  logic [3:0]      digit_q, digit_d;
  logic [7:0]      an_q, an_d;
  logic            dp_q, dp_d;
  logic            frame_done_q, frame_done_d;
  logic            cnt_wrap, frame_wrap, lit;

  always_comb begin
    cnt_wrap   = (cnt_q == LastC);
    frame_wrap = cnt_wrap && (slot_q == 3'd7);
    cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
    slot_d     = cnt_wrap ? slot_q + 3'd1 : slot_q;

    pend_value_d = pend_value_q;
    pend_en_d    = pend_en_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    act_value_d  = act_value_q;
    act_en_d     = act_en_q;
    act_dp_d     = act_dp_q;

    if (frame_wrap) begin
      // A strobe on the boundary itself bypasses the pending buffer.
      if (bus.load) begin
        act_value_d  = bus.value;
        act_en_d     = bus.digit_en;
        act_dp_d     = bus.dp_in;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        act_value_d  = pend_value_q;
        act_en_d     = pend_en_q;
        act_dp_d     = pend_dp_q;
        pend_valid_d = 1'b0;
      end
    end else if (bus.load) begin
      pend_value_d = bus.value;
      pend_en_d    = bus.digit_en;
      pend_dp_d    = bus.dp_in;
      pend_valid_d = 1'b1;
    end

    // Nibble changes together with the slot, taken from the post-boundary buffer.
    digit_d = cnt_wrap ? act_value_d[{slot_d, 2'b00} +: 4] : digit_q;

    // Blanking covers the decoder's register latency at each slot start.
    lit          = (cnt_d >= BlankC) && act_en_d[slot_d];
    an_d         = lit ? ~(8'd1 << slot_d) : 8'hFF;
    dp_d         = ~(lit && act_dp_d[slot_d]);
    frame_done_d = frame_wrap;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      slot_q       <= '0;
      pend_value_q <= '0;
      pend_en_q    <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      act_value_q  <= '0;
      act_en_q     <= '0;
      act_dp_q     <= '0;
      digit_q      <= '0;
      an_q         <= 8'hFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      pend_value_q <= pend_value_d;
      pend_en_q    <= pend_en_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      act_value_q  <= act_value_d;
      act_en_q     <= act_en_d;
      act_dp_q     <= act_dp_d;
      digit_q      <= digit_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit      = digit_q;
  assign AN         = an_q;
  assign DP         = dp_q;
  assign slot       = slot_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with DIV=8, BLANK=2.
module tb_display_scanner;

  logic       clock;
  logic       reset;
  logic [3:0] digit;
  logic [7:0] AN;
  logic       DP;
  logic [2:0] slot;
  logic       frame_done;

  int n_tests;
  int n_fail;

  display_scanner_if bus_if ();

  display_scanner #(
    .DIV   (8),
    .BLANK (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_if),
    .digit      (digit),
    .AN         (AN),
    .DP         (DP),
    .slot       (slot),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive_load(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp);
    bus_if.load     = 1'b1;
    bus_if.value    = v;
    bus_if.digit_en = en;
    bus_if.dp_in    = dp;
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      if (frame_done) seen = 1'b1;
    end
    check("frame_done_timeout", 32'(seen), 32'd1);
  endtask

  // Checks one full frame starting right after a boundary edge. Optional loads at
  // frame positions a_at / b_at (position j = slot*8 + cnt, -1 for none).
  task automatic scan_frame(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp,
                            input int a_at, input logic [31:0] a_v, input logic [7:0] a_en,
                            input logic [7:0] a_dp, input int b_at, input logic [31:0] b_v);
    for (int j = 0; j < 64; j++) begin
      int i;
      int c;
      logic [7:0] exp_an;
      logic       exp_dp;
      i      = j / 8;
      c      = j % 8;
      exp_an = (c >= 2 && en[i]) ? ~(8'd1 << i) : 8'hFF;
      exp_dp = (c >= 2 && en[i] && dp[i]) ? 1'b0 : 1'b1;
      check($sformatf("digit s%0d c%0d", i, c), 32'(digit), 32'(v[4*i +: 4]));
      check($sformatf("an s%0d c%0d", i, c), 32'(AN), 32'(exp_an));
      check($sformatf("dp s%0d c%0d", i, c), 32'(DP), 32'(exp_dp));
      check($sformatf("slot s%0d c%0d", i, c), 32'(slot), 32'(i));
      check($sformatf("frame_done s%0d c%0d", i, c), 32'(frame_done), 32'(j == 0));
      if (j == a_at) drive_load(a_v, a_en, a_dp);
      else if (j == b_at) drive_load(b_v, 8'hFF, 8'h00);
      else bus_if.load = 1'b0;
      tick();
    end
    bus_if.load = 1'b0;
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus_if.load     = 1'b0;
    bus_if.value    = '0;
    bus_if.digit_en = '0;
    bus_if.dp_in    = '0;

    // Reset behaviour: dark display, no frame pulses, no loads.
    repeat (3) tick();
    reset = 1'b0;
    for (int n = 0; n < 60; n++) begin
      check("rst_an", 32'(AN), 32'hFF);
      check("rst_dp", 32'(DP), 32'd1);
      check("rst_digit", 32'(digit), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      tick();
    end

    // Basic scan.
    drive_load(32'h76543210, 8'hFF, 8'h00);
    tick();
    bus_if.load = 1'b0;
    wait_frame();
    scan_frame(32'h76543210, 8'hFF, 8'h00, -1, '0, '0, '0, -1, '0);

    // No tearing: load during slot 3 only shows from the next frame.
    scan_frame(32'h76543210, 8'hFF, 8'h00, 24, 32'hFFFF_FFFF, 8'hFF, 8'h00, -1, '0);

    // Older value pending, then a strobe on the wrap cycle wins.
    scan_frame(32'hFFFF_FFFF, 8'hFF, 8'h00, 10, 32'h1111_1111, 8'hFF, 8'h00, 63, 32'h89AB_CDEF);
    // Masking load queued; the stale pending value must never appear.
    scan_frame(32'h89AB_CDEF, 8'hFF, 8'h00, 5, 32'h1357_2468, 8'h0F, 8'h01, -1, '0);
    scan_frame(32'h1357_2468, 8'h0F, 8'h01, -1, '0, '0, '0, -1, '0);

    // Reset mid-scan at slot 5, cnt 4, with a pending load and a same-cycle load.
    for (int j = 0; j < 44; j++) begin
      if (j == 10) drive_load(32'h5555_5555, 8'hFF, 8'hFF);
      else bus_if.load = 1'b0;
      tick();
    end
    check("pre_reset_slot", 32'(slot), 32'd5);
    reset = 1'b1;
    drive_load(32'hAAAA_AAAA, 8'hFF, 8'hFF);
    tick();
    reset       = 1'b0;
    bus_if.load = 1'b0;
    check("mid_rst_slot", 32'(slot), 32'd0);
    check("mid_rst_an", 32'(AN), 32'hFF);
    check("mid_rst_dp", 32'(DP), 32'd1);
    check("mid_rst_digit", 32'(digit), 32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    for (int t = 1; t <= 72; t++) begin
      tick();
      check($sformatf("dark_an t%0d", t), 32'(AN), 32'hFF);
      check($sformatf("dark_dp t%0d", t), 32'(DP), 32'd1);
      if (t == 7)  check("cnt_restart_slot0", 32'(slot), 32'd0);
      if (t == 8)  check("cnt_restart_slot1", 32'(slot), 32'd1);
      if (t == 64) check("post_rst_frame_done", 32'(frame_done), 32'd1);
    end

    // A fresh load lights the display again from the next boundary.
    drive_load(32'hFEDC_BA98, 8'hFF, 8'hA5);
    tick();
    bus_if.load = 1'b0;
    wait_frame();
    scan_frame(32'hFEDC_BA98, 8'hFF, 8'hA5, -1, '0, '0, '0, -1, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
